// File: rtl/mem_cmd_target.sv
// rtl/mem_cmd_target.sv - responder on the shared cmd/data bus with address pointer and RAM
//
// Decodes a 5-bit command every rising clk edge (op=cmd[4:2], len=cmd[1:0], inc=cmd[0]),
// keeps an address pointer into an internal synchronous RAM, and returns read/status words
// on the shared bidirectional data bus one cycle after the response is prepared.
//
// Ports:
//   clk    - bus clock, all state changes on the rising edge
//   rst_n  - synchronous active-low reset
//   cmd    - command from the initiator
//   data   - shared data bus, driven only while a response word is presented, else 'z
//   busy   - read response or burst in progress
//   err    - sticky protocol error, cleared only by reset
//
// Optional feature: define MEM_CMD_TARGET_BURST_EN to build the burst read (op 4, RDB).
// Without it op 4 is reserved and the BURST state and beat counter do not exist.
module mem_cmd_target #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        cmd,
    inout  wire  [DATA_W-1:0] data,
    output logic              busy,
    output logic              err
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_SETA = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_RD   = 3'd3;
    localparam logic [2:0] OP_STAT = 3'd5;
`ifdef MEM_CMD_TARGET_BURST_EN
    localparam logic [2:0] OP_RDB  = 3'd4;
`endif

    localparam logic [31:0]       DEPTH_U   = 32'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

`ifdef MEM_CMD_TARGET_BURST_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, BURST = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1} state_t;
`endif

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt, addr_inc, seta_addr;
    logic                err_q, err_nxt;
    logic                oe;
    logic [DATA_W-1:0]   dout;
    logic [DATA_W-1:0]   rd_q;
    logic [DATA_W-1:0]   stat_word;
    logic                mem_we, ld_mem, ld_stat;
    logic                can_start;
    logic [2:0]          op;
    logic                inc;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef MEM_CMD_TARGET_BURST_EN
    logic [1:0]          cnt, cnt_nxt;
    logic [1:0]          len;
    assign len = cmd[1:0];
`else
    logic                unused_len;
    assign unused_len = cmd[1];
`endif

    assign op   = cmd[4:2];
    assign inc  = cmd[0];
    assign busy = (state != IDLE);
    assign err  = err_q;

    // The response word is captured into rd_q on the accepting edge and moved into dout one
    // edge later, so rd_q can already take the next word of a back-to-back read or burst.
    assign data = oe ? dout : {DATA_W{1'bz}};

    assign addr_inc  = (addr == ADDR_LAST) ? '0 : addr + ADDR_W'(1);
    assign seta_addr = ADDR_W'({{(32-ADDR_W){1'b0}}, data[ADDR_W-1:0]} % DEPTH_U);

    // RESP lasts exactly one cycle, so any edge seen in RESP is the edge where it ends and a
    // new read may chain onto it without a gap on the bus.
    assign can_start = (state == IDLE) || (state == RESP);

    always_comb begin
        stat_word           = '0;
        stat_word[DATA_W-1] = err_q;
        stat_word[DATA_W-2] = busy;
        stat_word[1:0]      = addr[1:0];
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        err_nxt   = err_q;
        mem_we    = 1'b0;
        ld_mem    = 1'b0;
        ld_stat   = 1'b0;
`ifdef MEM_CMD_TARGET_BURST_EN
        cnt_nxt   = cnt;
`endif

        case (state)
            RESP: state_nxt = IDLE;
`ifdef MEM_CMD_TARGET_BURST_EN
            BURST: begin
                // cnt counts the beats still to fetch; at zero the last beat is already in rd_q
                if (cnt == 2'd0) begin
                    state_nxt = IDLE;
                end else begin
                    ld_mem   = 1'b1;
                    addr_nxt = addr_inc;
                    cnt_nxt  = cnt - 2'd1;
                end
            end
`endif
            default: ;
        endcase

        case (op)
            OP_NOP: ;
            OP_SETA: begin
                if (busy) err_nxt = 1'b1;
                else      addr_nxt = seta_addr;
            end
            OP_WR: begin
                // oe covers the presentation cycle after busy drops: writing then would fight the bus
                if (busy || oe) begin
                    err_nxt = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    if (inc) addr_nxt = addr_inc;
                end
            end
            OP_RD: begin
                if (!can_start) begin
                    err_nxt = 1'b1;
                end else begin
                    state_nxt = RESP;
                    ld_mem    = 1'b1;
                    if (inc) addr_nxt = addr_inc;
                end
            end
            OP_STAT: begin
                if (!can_start) begin
                    err_nxt = 1'b1;
                end else begin
                    state_nxt = RESP;
                    ld_stat   = 1'b1;
                end
            end
`ifdef MEM_CMD_TARGET_BURST_EN
            OP_RDB: begin
                if (!can_start) begin
                    err_nxt = 1'b1;
                end else begin
                    state_nxt = BURST;
                    ld_mem    = 1'b1;
                    addr_nxt  = addr_inc;
                    cnt_nxt   = len;
                end
            end
`endif
            default: err_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= '0;
            err_q <= 1'b0;
            oe    <= 1'b0;
`ifdef MEM_CMD_TARGET_BURST_EN
            cnt   <= 2'd0;
`endif
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            err_q <= err_nxt;
            // every busy cycle prepares exactly one word, presented during the following cycle
            oe    <= busy;
`ifdef MEM_CMD_TARGET_BURST_EN
            cnt   <= cnt_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem[addr] <= data;
        if (rst_n && ld_mem)       rd_q <= mem[addr];
        else if (rst_n && ld_stat) rd_q <= stat_word;
        if (busy) dout <= rd_q;
    end

endmodule

// File: tb/tb_mem_cmd_target.sv
// tb/tb_mem_cmd_target.sv - self-checking bench for mem_cmd_target
module tb_mem_cmd_target;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
`ifdef MEM_CMD_TARGET_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] cmd = 5'd0;
    wire  [7:0] data;
    logic       busy;
    logic       err;
    logic       tb_oe = 1'b1;
    logic [7:0] tb_dout = 8'h00;

    assign data = tb_oe ? tb_dout : 8'bz;

    mem_cmd_target #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cmd),
        .data  (data),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: the bus is a schedule of words keyed by the edge that starts their
    // presentation; busy is "until edge busy_last"; RAM is a plain array.
    logic [7:0] m_mem [DEPTH];
    logic [7:0] drv [int];
    int         m_addr    = 0;
    bit         m_err     = 1'b0;
    int         busy_last = -1;
    bit         last_resp = 1'b0;

    task automatic model_edge(input bit r_n, input logic [4:0] c, input logic [7:0] d);
        int t;
        bit busy_m, resp_end, driving, can_start;
        int op, len;
        t         = cyc;
        busy_m    = (t <= busy_last);
        resp_end  = busy_m && (t == busy_last) && last_resp;
        driving   = drv.exists(t - 1) != 0;
        can_start = !busy_m || resp_end;
        op        = int'(c[4:2]);
        len       = int'(c[1:0]);
        if (!r_n) begin
            m_addr = 0; m_err = 1'b0; busy_last = -1; last_resp = 1'b0;
            drv.delete();
            return;
        end
        case (op)
            0: ;
            1: if (busy_m) m_err = 1'b1; else m_addr = int'(d) % DEPTH;
            2: if (busy_m || driving) m_err = 1'b1;
               else begin
                   m_mem[m_addr] = d;
                   if (c[0]) m_addr = (m_addr + 1) % DEPTH;
               end
            3: if (!can_start) m_err = 1'b1;
               else begin
                   drv[t + 1] = m_mem[m_addr];
                   busy_last = t + 1; last_resp = 1'b1;
                   if (c[0]) m_addr = (m_addr + 1) % DEPTH;
               end
            5: if (!can_start) m_err = 1'b1;
               else begin
                   drv[t + 1] = {m_err, busy_m, 4'b0000, 2'(m_addr % 4)};
                   busy_last = t + 1; last_resp = 1'b1;
               end
            4: if (!BURST_EN || !can_start) m_err = 1'b1;
               else begin
                   for (int k = 0; k <= len; k++) begin
                       drv[t + 1 + k] = m_mem[m_addr];
                       m_addr = (m_addr + 1) % DEPTH;
                   end
                   busy_last = t + 1 + len; last_resp = 1'b0;
               end
            default: m_err = 1'b1;
        endcase
    endtask

    // Apply one command for the next edge, advance the model, then compare at the falling edge.
    task automatic step(input bit r_n, input logic [2:0] op, input logic [1:0] lo, input logic [7:0] d);
        rst_n   = r_n;
        cmd     = {op, lo};
        tb_dout = d;
        @(posedge clk);
        cyc++;
        model_edge(r_n, {op, lo}, d);
        #1;
        tb_oe = (drv.exists(cyc) == 0);
        @(negedge clk);
        check("busy", 32'(busy), 32'(cyc + 1 <= busy_last));
        check("err",  32'(err),  32'(m_err));
        check("data", 32'(data), 32'(drv.exists(cyc) ? drv[cyc] : tb_dout));
    endtask

    initial begin
        int r;
        logic [2:0] op;

        step(1'b0, 3'd0, 2'd0, 8'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_release", 32'(data), 32'(tb_dout));
        step(1'b1, 3'd0, 2'd0, 8'h00);

        step(1'b1, 3'd1, 2'd0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 3'd2, 2'd1, 8'($urandom));

        // single read with two-edge latency
        step(1'b1, 3'd1, 2'd0, 8'h10);
        step(1'b1, 3'd2, 2'd0, 8'hA5);
        step(1'b1, 3'd3, 2'd0, 8'h00);
        check("t1_busy", 32'(busy), 32'd1);
        step(1'b1, 3'd0, 2'd0, 8'h00);
        check("t1_data", 32'(data), 32'hA5);
        check("t1_busy_end", 32'(busy), 32'd0);
        step(1'b1, 3'd0, 2'd0, 8'h5A);
        check("t1_release", 32'(data), 32'h5A);

        // address wrap and back-to-back STAT at the end of RESP
        step(1'b1, 3'd1, 2'd0, 8'h00);
        step(1'b1, 3'd2, 2'd0, 8'h77);
        step(1'b1, 3'd1, 2'd0, 8'hFF);
        step(1'b1, 3'd2, 2'd1, 8'h11);
        step(1'b1, 3'd3, 2'd0, 8'h00);
        step(1'b1, 3'd5, 2'd0, 8'h00);
        check("t2_wrap", 32'(data), 32'h77);
        step(1'b1, 3'd0, 2'd0, 8'h00);
        check("t2_stat", 32'(data), 32'h40);
        step(1'b1, 3'd0, 2'd0, 8'h00);

        if (BURST_EN) begin
            step(1'b1, 3'd1, 2'd0, 8'h04);
            for (int i = 1; i <= 4; i++) step(1'b1, 3'd2, 2'd1, 8'(i));
            step(1'b1, 3'd1, 2'd0, 8'h04);
            step(1'b1, 3'd4, 2'd3, 8'h00);
            check("t3_busy0", 32'(busy), 32'd1);
            for (int k = 0; k < 4; k++) begin
                step(1'b1, 3'd0, 2'd0, 8'h00);
                check("t3_beat", 32'(data), 32'(k + 1));
                check("t3_busy", 32'(busy), 32'(k < 3));
            end
            step(1'b1, 3'd0, 2'd0, 8'hC3);
            check("t3_release", 32'(data), 32'hC3);
        end

        // write during read response is rejected
        step(1'b1, 3'd3, 2'd0, 8'h00);
        step(1'b1, 3'd2, 2'd0, 8'h55);
        check("t4_err", 32'(err), 32'd1);
        step(1'b1, 3'd0, 2'd0, 8'h00);
        step(1'b1, 3'd5, 2'd0, 8'h00);
        step(1'b1, 3'd0, 2'd0, 8'h00);
        check("t4_stat_msb", 32'(data[7]), 32'd1);
        step(1'b0, 3'd0, 2'd0, 8'h00);
        step(1'b1, 3'd0, 2'd0, 8'h00);

        if (BURST_EN) begin
            step(1'b1, 3'd6, 2'd0, 8'h00);
            step(1'b1, 3'd1, 2'd0, 8'h04);
            step(1'b1, 3'd4, 2'd3, 8'h00);
            step(1'b1, 3'd0, 2'd0, 8'h00);
            step(1'b0, 3'd0, 2'd0, 8'h3C);
            check("t5_release", 32'(data), 32'h3C);
            check("t5_busy", 32'(busy), 32'd0);
            check("t5_err", 32'(err), 32'd0);
            step(1'b1, 3'd1, 2'd0, 8'h05);
            step(1'b1, 3'd3, 2'd0, 8'h00);
            step(1'b1, 3'd0, 2'd0, 8'h00);
            check("t5_ram", 32'(data), 32'h02);
        end

        step(1'b1, 3'd6, 2'd0, 8'h00);
        check("t6_err", 32'(err), 32'd1);
        if (!BURST_EN) begin
            step(1'b0, 3'd0, 2'd0, 8'h00);
            step(1'b1, 3'd4, 2'd3, 8'h00);
            check("t6_rdb_err", 32'(err), 32'd1);
            step(1'b1, 3'd0, 2'd0, 8'h99);
            check("t6_nodrive", 32'(data), 32'h99);
        end

        step(1'b0, 3'd0, 2'd0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                step(1'b0, 3'($urandom), 2'($urandom), 8'($urandom));
            end else begin
                if (r < 4) op = 3'($urandom_range(6, 7));
                else       op = 3'($urandom_range(0, 5));
                if (op == 3'd1 && drv.exists(cyc)) op = 3'd0;
                step(1'b1, op, 2'($urandom), 8'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
